// File: rtl/idex_hazard_stage_if.sv
// Signal bundle between the ID stage, the ID/EX hazard stage and its consumers.
// The stage itself uses the slave modport; the ID-side driver uses master.
interface idex_hazard_stage_if;
  logic        ID_valid;
  logic [31:0] ID_pc;
  logic [31:0] ID_imm;
  logic [31:0] ID_rs1_data;
  logic [31:0] ID_rs2_data;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic [4:0]  ID_rd;
  logic        ID_uses_rs1;
  logic        ID_uses_rs2;
  logic        ID_rd_wren;
  logic        ID_mem_rden;
  logic        ID_mem_wren;
  logic [3:0]  ID_alu_op;
  logic [1:0]  ID_wb_sel;
  logic        EX_flush;
  logic        ext_stall;

  logic        IDEX_valid;
  logic [31:0] IDEX_pc;
  logic [31:0] IDEX_imm;
  logic [31:0] IDEX_rs1_data;
  logic [31:0] IDEX_rs2_data;
  logic [4:0]  IDEX_rs1;
  logic [4:0]  IDEX_rs2;
  logic [4:0]  IDEX_rd;
  logic        IDEX_rd_wren;
  logic        IDEX_mem_rden;
  logic        IDEX_mem_wren;
  logic [3:0]  IDEX_alu_op;
  logic [1:0]  IDEX_wb_sel;
  logic        ifid_hold;
  logic        ifid_flush;
  logic [15:0] bubble_cnt;

  modport master (
    output ID_valid, ID_pc, ID_imm, ID_rs1_data, ID_rs2_data, ID_rs1, ID_rs2, ID_rd,
           ID_uses_rs1, ID_uses_rs2, ID_rd_wren, ID_mem_rden, ID_mem_wren,
           ID_alu_op, ID_wb_sel, EX_flush, ext_stall,
    input  IDEX_valid, IDEX_pc, IDEX_imm, IDEX_rs1_data, IDEX_rs2_data, IDEX_rs1,
           IDEX_rs2, IDEX_rd, IDEX_rd_wren, IDEX_mem_rden, IDEX_mem_wren,
           IDEX_alu_op, IDEX_wb_sel, ifid_hold, ifid_flush, bubble_cnt
  );

  modport slave (
    input  ID_valid, ID_pc, ID_imm, ID_rs1_data, ID_rs2_data, ID_rs1, ID_rs2, ID_rd,
           ID_uses_rs1, ID_uses_rs2, ID_rd_wren, ID_mem_rden, ID_mem_wren,
           ID_alu_op, ID_wb_sel, EX_flush, ext_stall,
    output IDEX_valid, IDEX_pc, IDEX_imm, IDEX_rs1_data, IDEX_rs2_data, IDEX_rs1,
           IDEX_rs2, IDEX_rd, IDEX_rd_wren, IDEX_mem_rden, IDEX_mem_wren,
           IDEX_alu_op, IDEX_wb_sel, ifid_hold, ifid_flush, bubble_cnt
  );
endinterface

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazards and EX branch flushes, and the IF/ID hold/flush controls.
module idex_hazard_stage (
  input  logic               clk,
  input  logic               rst,
  idex_hazard_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wren;
    logic        mem_rden;
    logic        mem_wren;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
  } idex_t;

  idex_t       idex_q, idex_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        lu;
  logic        rs1_hit, rs2_hit;

  // A load in EX whose destination is read by the instruction now in ID.
  assign rs1_hit = bus.ID_uses_rs1 & (bus.ID_rs1 == idex_q.rd);
  assign rs2_hit = bus.ID_uses_rs2 & (bus.ID_rs2 == idex_q.rd);
  assign lu      = idex_q.valid & idex_q.mem_rden & (idex_q.rd != 5'd0) &
                   bus.ID_valid & (rs1_hit | rs2_hit);

  always_comb begin
    idex_d       = idex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.ext_stall) begin
      idex_d       = idex_q;
    end else if (bus.EX_flush) begin
      idex_d       = '0;
    end else if (lu) begin
      idex_d       = '0;
      bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q : bubble_cnt_q + 16'd1;
    end else begin
      idex_d.valid    = bus.ID_valid;
      idex_d.pc       = bus.ID_pc;
      idex_d.imm      = bus.ID_imm;
      idex_d.rs1_data = bus.ID_rs1_data;
      idex_d.rs2_data = bus.ID_rs2_data;
      idex_d.rs1      = bus.ID_rs1;
      idex_d.rs2      = bus.ID_rs2;
      idex_d.rd       = bus.ID_rd;
      // x0 writes are dropped here so forwarding never needs an x0 check.
      idex_d.rd_wren  = bus.ID_rd_wren & bus.ID_valid & (bus.ID_rd != 5'd0);
      idex_d.mem_rden = bus.ID_mem_rden & bus.ID_valid;
      idex_d.mem_wren = bus.ID_mem_wren & bus.ID_valid;
      idex_d.alu_op   = bus.ID_alu_op;
      idex_d.wb_sel   = bus.ID_wb_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q       <= '0;
      bubble_cnt_q <= 16'd0;
    end else begin
      idex_q       <= idex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Reset forces IF/ID to a bubble; otherwise a flush overrides a load-use hold.
  assign bus.ifid_hold  = ~rst & (bus.ext_stall | (lu & ~bus.EX_flush));
  assign bus.ifid_flush = rst | (bus.EX_flush & ~bus.ext_stall);

  assign bus.IDEX_valid    = idex_q.valid;
  assign bus.IDEX_pc       = idex_q.pc;
  assign bus.IDEX_imm      = idex_q.imm;
  assign bus.IDEX_rs1_data = idex_q.rs1_data;
  assign bus.IDEX_rs2_data = idex_q.rs2_data;
  assign bus.IDEX_rs1      = idex_q.rs1;
  assign bus.IDEX_rs2      = idex_q.rs2;
  assign bus.IDEX_rd       = idex_q.rd;
  assign bus.IDEX_rd_wren  = idex_q.rd_wren;
  assign bus.IDEX_mem_rden = idex_q.mem_rden;
  assign bus.IDEX_mem_wren = idex_q.mem_wren;
  assign bus.IDEX_alu_op   = idex_q.alu_op;
  assign bus.IDEX_wb_sel   = idex_q.wb_sel;
  assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed bench for idex_hazard_stage: reset, load-use stalls, false hazards,
// flush priority, external stall, back-to-back loads and counter saturation.
module tb_idex_hazard_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  idex_hazard_stage_if bus ();

  idex_hazard_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic wren, input logic mrd, input logic mwr);
    bus.ID_valid    = v;
    bus.ID_pc       = pc;
    bus.ID_imm      = pc ^ 32'hA5A5_0000;
    bus.ID_rs1_data = pc + 32'd1;
    bus.ID_rs2_data = pc + 32'd2;
    bus.ID_rs1      = rs1;
    bus.ID_rs2      = rs2;
    bus.ID_rd       = rd;
    bus.ID_uses_rs1 = u1;
    bus.ID_uses_rs2 = u2;
    bus.ID_rd_wren  = wren;
    bus.ID_mem_rden = mrd;
    bus.ID_mem_wren = mwr;
    bus.ID_alu_op   = pc[5:2];
    bus.ID_wb_sel   = pc[3:2];
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.EX_flush  = 1'b0;
    bus.ext_stall = 1'b0;
    drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    total++; if (bus.IDEX_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.IDEX_valid); end
    total++; if (bus.IDEX_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.IDEX_pc); end
    total++; if ({bus.IDEX_rd, bus.IDEX_rd_wren, bus.IDEX_mem_rden, bus.IDEX_mem_wren} !== 8'h0) begin
      bad++; $display("FAIL reset_ctrl got rd=%0d wren=%b rden=%b mwr=%b want all 0",
                      bus.IDEX_rd, bus.IDEX_rd_wren, bus.IDEX_mem_rden, bus.IDEX_mem_wren); end
    total++; if (bus.bubble_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", bus.bubble_cnt); end
    total++; if (bus.ifid_flush !== 1'b1) begin bad++; $display("FAIL reset_flush got=%b want=1", bus.ifid_flush); end
    total++; if (bus.ifid_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", bus.ifid_hold); end
    rst = 1'b0;
    idle();
    step();
    exp_cnt = 16'd0;
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (bus.ifid_hold !== 1'b0) begin bad++; $display("FAIL lu_pre_hold got=%b want=0", bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_mem_rden, bus.IDEX_rd} !== {1'b1, 1'b1, 5'd5}) begin
      bad++; $display("FAIL lu_load_cap got v=%b rden=%b rd=%0d want 1 1 5", bus.IDEX_valid, bus.IDEX_mem_rden, bus.IDEX_rd); end
    drive(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if ({bus.ifid_hold, bus.ifid_flush} !== 2'b10) begin
      bad++; $display("FAIL lu_hold got hold=%b flush=%b want 1 0", bus.ifid_hold, bus.ifid_flush); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if ({bus.IDEX_valid, bus.IDEX_rd, bus.IDEX_pc} !== {1'b0, 5'd0, 32'h0}) begin
      bad++; $display("FAIL lu_bubble got v=%b rd=%0d pc=%h want 0 0 0", bus.IDEX_valid, bus.IDEX_rd, bus.IDEX_pc); end
    total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt got=%h want=%h", bus.bubble_cnt, exp_cnt); end
    total++; if (bus.ifid_hold !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%b want=0", bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_rd_wren} !== {1'b1, 32'h104, 5'd6, 1'b1}) begin
      bad++; $display("FAIL lu_add_cap got v=%b pc=%h rd=%0d wren=%b want 1 104 6 1",
                      bus.IDEX_valid, bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_rd_wren); end
    total++; if ({bus.IDEX_imm, bus.IDEX_rs1_data, bus.IDEX_rs2_data} !== {32'hA5A5_0104, 32'h105, 32'h106}) begin
      bad++; $display("FAIL lu_add_data got imm=%h d1=%h d2=%h want a5a50104 105 106",
                      bus.IDEX_imm, bus.IDEX_rs1_data, bus.IDEX_rs2_data); end
    total++; if ({bus.IDEX_rs1, bus.IDEX_rs2, bus.IDEX_alu_op, bus.IDEX_wb_sel} !== {5'd5, 5'd7, 4'h1, 2'h1}) begin
      bad++; $display("FAIL lu_add_fields got rs1=%0d rs2=%0d op=%h wb=%h want 5 7 1 1",
                      bus.IDEX_rs1, bus.IDEX_rs2, bus.IDEX_alu_op, bus.IDEX_wb_sel); end
  endtask

  task automatic test_false_hazards();
    drive(1'b1, 32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    total++; if ({bus.IDEX_rd_wren, bus.IDEX_mem_rden} !== 2'b01) begin
      bad++; $display("FAIL x0_wren got wren=%b rden=%b want 0 1", bus.IDEX_rd_wren, bus.IDEX_mem_rden); end
    drive(1'b1, 32'h204, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus.ifid_hold !== 1'b0) begin bad++; $display("FAIL x0_no_stall got=%b want=0", bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_pc} !== {1'b1, 32'h204}) begin
      bad++; $display("FAIL x0_cap got v=%b pc=%h want 1 204", bus.IDEX_valid, bus.IDEX_pc); end
    drive(1'b1, 32'h208, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h20C, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus.ifid_hold !== 1'b0) begin bad++; $display("FAIL lui_no_stall got=%b want=0", bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_pc, bus.IDEX_rd_wren} !== {32'h20C, 1'b1}) begin
      bad++; $display("FAIL lui_cap got pc=%h wren=%b want 20c 1", bus.IDEX_pc, bus.IDEX_rd_wren); end
    drive(1'b0, 32'h210, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_rd, bus.IDEX_rd_wren, bus.IDEX_mem_rden, bus.IDEX_mem_wren} !== {1'b0, 5'd3, 3'b000}) begin
      bad++; $display("FAIL invalid_gate got v=%b rd=%0d wren=%b rden=%b mwr=%b want 0 3 0 0 0",
                      bus.IDEX_valid, bus.IDEX_rd, bus.IDEX_rd_wren, bus.IDEX_mem_rden, bus.IDEX_mem_wren); end
    total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL false_cnt got=%h want=%h", bus.bubble_cnt, exp_cnt); end
  endtask

  task automatic test_flush_vs_lu();
    drive(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h304, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.EX_flush = 1'b1;
    #1;
    total++; if ({bus.ifid_flush, bus.ifid_hold} !== 2'b10) begin
      bad++; $display("FAIL fl_ctrl got flush=%b hold=%b want 1 0", bus.ifid_flush, bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_pc} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL fl_bubble got v=%b pc=%h want 0 0", bus.IDEX_valid, bus.IDEX_pc); end
    total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL fl_cnt got=%h want=%h", bus.bubble_cnt, exp_cnt); end
    bus.EX_flush = 1'b0;
    idle();
    step();
  endtask

  task automatic test_ext_stall();
    drive(1'b1, 32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h404, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.EX_flush  = 1'b1;
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bus.ifid_hold, bus.ifid_flush} !== 2'b10) begin
        bad++; $display("FAIL st_ctrl[%0d] got hold=%b flush=%b want 1 0", i, bus.ifid_hold, bus.ifid_flush); end
      step();
      total++; if ({bus.IDEX_valid, bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_mem_rden} !== {1'b1, 32'h400, 5'd5, 1'b1}) begin
        bad++; $display("FAIL st_hold[%0d] got v=%b pc=%h rd=%0d rden=%b want 1 400 5 1",
                        i, bus.IDEX_valid, bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_mem_rden); end
      total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL st_cnt[%0d] got=%h want=%h", i, bus.bubble_cnt, exp_cnt); end
    end
    bus.ext_stall = 1'b0;
    #1;
    total++; if ({bus.ifid_flush, bus.ifid_hold} !== 2'b10) begin
      bad++; $display("FAIL st_rel_ctrl got flush=%b hold=%b want 1 0", bus.ifid_flush, bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_pc} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL st_rel_bubble got v=%b pc=%h want 0 0", bus.IDEX_valid, bus.IDEX_pc); end
    total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL st_rel_cnt got=%h want=%h", bus.bubble_cnt, exp_cnt); end
    bus.EX_flush = 1'b0;
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h504, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (bus.ifid_hold !== 1'b1) begin bad++; $display("FAIL b2b_hold1 got=%b want=1", bus.ifid_hold); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if ({bus.IDEX_valid, bus.ifid_hold} !== 2'b00) begin
      bad++; $display("FAIL b2b_bubble1 got v=%b hold=%b want 0 0", bus.IDEX_valid, bus.ifid_hold); end
    step();
    total++; if ({bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_mem_rden} !== {32'h504, 5'd6, 1'b1}) begin
      bad++; $display("FAIL b2b_load2 got pc=%h rd=%0d rden=%b want 504 6 1", bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_mem_rden); end
    drive(1'b1, 32'h508, 5'd1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus.ifid_hold !== 1'b1) begin bad++; $display("FAIL b2b_hold2 got=%b want=1", bus.ifid_hold); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if ({bus.IDEX_valid, bus.ifid_hold} !== 2'b00) begin
      bad++; $display("FAIL b2b_bubble2 got v=%b hold=%b want 0 0", bus.IDEX_valid, bus.ifid_hold); end
    total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%h want=%h", bus.bubble_cnt, exp_cnt); end
    step();
    total++; if ({bus.IDEX_valid, bus.IDEX_pc} !== {1'b1, 32'h508}) begin
      bad++; $display("FAIL b2b_use got v=%b pc=%h want 1 508", bus.IDEX_valid, bus.IDEX_pc); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h600, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h604, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    total++; if ({bus.ifid_hold, bus.ifid_flush} !== 2'b01) begin
      bad++; $display("FAIL rms_ctrl got hold=%b flush=%b want 0 1", bus.ifid_hold, bus.ifid_flush); end
    step();
    exp_cnt = 16'd0;
    total++; if ({bus.IDEX_valid, bus.IDEX_pc, bus.bubble_cnt} !== {1'b0, 32'h0, 16'h0}) begin
      bad++; $display("FAIL rms_state got v=%b pc=%h cnt=%h want 0 0 0", bus.IDEX_valid, bus.IDEX_pc, bus.bubble_cnt); end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_saturation();
    idle();
    force dut.bubble_cnt_q = 16'hFFFD;
    step();
    release dut.bubble_cnt_q;
    step();
    exp_cnt = 16'hFFFD;
    total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL sat_preload got=%h want=%h", bus.bubble_cnt, exp_cnt); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h700, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'h704, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      total++; if (bus.bubble_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt[%0d] got=%h want=%h", i, bus.bubble_cnt, exp_cnt); end
    end
    total++; if (bus.bubble_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_final got=%h want=ffff", bus.bubble_cnt); end
  endtask

  initial begin
    bus.EX_flush  = 1'b0;
    bus.ext_stall = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_false_hazards();
    test_flush_vs_lu();
    test_ext_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
